// File: rtl/input_register_fifo.sv
// First-word-fall-through FIFO with valid/ready on both sides, synchronous clear and
// occupancy/full/empty status. Replaces the single-stage input register at DP/SMAC boundaries.
module input_register_fifo #(
  parameter int unsigned M = 16,
  parameter int unsigned D = 4,
  localparam int unsigned AW = $clog2(D)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cl_en,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [M-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [M-1:0]  out_data,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW:0] DepthCnt = (AW + 1)'(D);

  logic [M-1:0]  mem_q [D];
  logic [M-1:0]  mem_d [D];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          push, pop;

  assign full      = (cnt_q == DepthCnt);
  assign empty     = (cnt_q == '0);
  assign count     = cnt_q;
  // No ready pass-through: a pop in the same cycle does not free a full buffer for a push.
  assign in_ready  = rst_n & ~full & ~cl_en;
  assign out_valid = ~empty & ~cl_en;
  assign out_data  = empty ? '0 : mem_q[rd_ptr_q];

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (cl_en) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = in_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop) begin
        cnt_d = cnt_q + 1'b1;
      end else if (pop && !push) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; stale words are masked by empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_input_register_fifo.sv
// Directed self-checking bench for input_register_fifo at M=16, D=4.
module tb_input_register_fifo;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cl_en = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int checks = 0;
  int errors = 0;

  input_register_fifo #(.M(16), .D(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cl_en     (cl_en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs change 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", count); end
    checks++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      errors++; $display("FAIL reset_flags got empty=%b full=%b want 1 0", empty, full);
    end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++;
    if (out_valid !== 1'b0 || out_data !== 16'h0) begin
      errors++; $display("FAIL reset_out got v=%b d=%h want 0 0000", out_valid, out_data);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_fill();
    tick();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(i);
      tick();
      #1;
      checks++;
      if (count !== 3'(i)) begin errors++; $display("FAIL fill_count got %0d want %0d", count, i); end
      checks++;
      if (out_valid !== 1'b1 || out_data !== 16'h0001) begin
        errors++; $display("FAIL fill_head got v=%b d=%h want 1 0001", out_valid, out_data);
      end
    end
    checks++;
    if (full !== 1'b1 || in_ready !== 1'b0) begin
      errors++; $display("FAIL fill_full got full=%b in_ready=%b want 1 0", full, in_ready);
    end
  endtask

  task automatic test_push_on_full();
    in_valid  = 1'b1;
    in_data   = 16'h0005;
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b0 || out_data !== 16'h0001) begin
      errors++; $display("FAIL full_pop_cycle got in_ready=%b d=%h want 0 0001", in_ready, out_data);
    end
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    checks++;
    if (count !== 3'd3 || in_ready !== 1'b1) begin
      errors++; $display("FAIL full_after got count=%0d in_ready=%b want 3 1", count, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      #1;
      checks++;
      if (out_data !== 16'(i)) begin errors++; $display("FAIL drain_data got %h want %h", out_data, 16'(i)); end
      tick();
    end
    out_ready = 1'b0;
    #1;
    checks++;
    if (empty !== 1'b1 || out_data !== 16'h0) begin
      errors++; $display("FAIL drain_empty got empty=%b d=%h want 1 0000 (0005 dropped)", empty, out_data);
    end
  endtask

  task automatic test_stream_wrap();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 12; k++) begin
      in_data = 16'h0010 + 16'(k);
      #1;
      checks++;
      if (k == 0) begin
        if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_bypass got v=%b want 0", out_valid); end
      end else if (out_valid !== 1'b1 || out_data !== 16'h0010 + 16'(k - 1) || count !== 3'd1) begin
        errors++;
        $display("FAIL stream_data got v=%b d=%h c=%0d want 1 %h 1", out_valid, out_data, count,
                 16'h0010 + 16'(k - 1));
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_data !== 16'h001B || count !== 3'd1) begin
      errors++; $display("FAIL stream_last got d=%h c=%0d want 001b 1", out_data, count);
    end
    tick();
    out_ready = 1'b0;
    #1;
    checks++;
    if (empty !== 1'b1) begin errors++; $display("FAIL stream_empty got %b want 1", empty); end
  endtask

  task automatic test_simultaneous();
    in_valid = 1'b1;
    in_data  = 16'hB001;
    tick();
    in_data  = 16'hB002;
    tick();
    in_data   = 16'hAAAA;
    out_ready = 1'b1;
    #1;
    checks++;
    if (count !== 3'd2 || out_data !== 16'hB001) begin
      errors++; $display("FAIL sim_pre got c=%0d d=%h want 2 b001", count, out_data);
    end
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (count !== 3'd2 || out_data !== 16'hB002) begin
      errors++; $display("FAIL sim_mid got c=%0d d=%h want 2 b002", count, out_data);
    end
    tick();
    #1;
    checks++;
    if (count !== 3'd1 || out_data !== 16'hAAAA) begin
      errors++; $display("FAIL sim_new got c=%0d d=%h want 1 aaaa", count, out_data);
    end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_clear();
    in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      in_data = 16'h00C0 + 16'(i);
      tick();
    end
    cl_en     = 1'b1;
    in_data   = 16'h00C4;
    out_ready = 1'b1;
    #1;
    checks++;
    if (count !== 3'd3 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_cycle got c=%0d in_ready=%b v=%b want 3 0 0", count, in_ready, out_valid);
    end
    tick();
    cl_en     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || empty !== 1'b1 || out_data !== 16'h0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL clr_after got c=%0d e=%b d=%h in_ready=%b want 0 1 0000 1", count, empty,
               out_data, in_ready);
    end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1;
    in_data  = 16'h00D1;
    tick();
    in_data  = 16'h00D2;
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (count !== 3'd2) begin errors++; $display("FAIL arst_pre got c=%0d want 2", count); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== 16'h0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL arst_now got c=%0d v=%b d=%h in_ready=%b want 0 0 0000 0", count, out_valid,
               out_data, in_ready);
    end
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'h1234;
    tick();
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h1234 || count !== 3'd1) begin
      errors++; $display("FAIL arst_push got v=%b d=%h c=%0d want 1 1234 1", out_valid, out_data, count);
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_push_on_full();
    test_stream_wrap();
    test_simultaneous();
    test_clear();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
